// File: rtl/redun_result_serializer.sv
// redun_result_serializer
//   Captures one redundant-form result (NUM_WRDS words of WRD_BITS+1 bits),
//   resolves the inter-word carries serially and streams the canonical
//   DAT_BITS-bit value out as OUT_BITS-bit beats, least-significant first.
//   Only a beat-wide adder is used; the carry travels between beats.
//
// Optional build macro:
//   REDUN_SER_DBUF_EN - adds a shadow capture register so the next result can
//                       be accepted while the current one streams, giving
//                       back-to-back streams with no idle cycle in between.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_dat/i_val/o_rdy  redundant result input (word k at [k*(WRD_BITS+1) +: WRD_BITS+1])
//   o_dat/o_val/i_rdy  output beat stream
//   o_last           final beat of a result
//   o_ovf            final beat carries bits at or above DAT_BITS (valid with o_last)
module redun_result_serializer #(
  parameter int WRD_BITS  = 16,
  parameter int NUM_WRDS  = 65,
  parameter int OUT_BITS  = 32,
  parameter int NUM_BEATS = (NUM_WRDS*WRD_BITS + OUT_BITS - 1) / OUT_BITS
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   i_dat,
  input  logic                               i_val,
  output logic                               o_rdy,
  output logic [OUT_BITS-1:0]                o_dat,
  output logic                               o_val,
  input  logic                               i_rdy,
  output logic                               o_last,
  output logic                               o_ovf
);
  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int WPB      = OUT_BITS / WRD_BITS;
  localparam int NW_PAD   = NUM_BEATS * WPB;   // word slots covered by the beats
  localparam int CAP_W    = NUM_WRDS * (WRD_BITS + 1);
  localparam int KW       = $clog2(NUM_BEATS + 1);
  localparam int IW       = $clog2(NW_PAD);
  localparam int SW       = OUT_BITS + 2;
  localparam int TOP_LSB  = DAT_BITS - (NUM_BEATS - 1) * OUT_BITS;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic               up_q;      // goes high one edge after reset release
  logic [KW-1:0]      k_q;
  logic [1:0]         carry_q;
  logic [CAP_W-1:0]   act_q;
`ifdef REDUN_SER_DBUF_EN
  logic [CAP_W-1:0]   sh_q;
  logic               sh_full;
`endif

  // Word view of the active register, zero-padded to a whole number of beats
  // so the last beat can read past NUM_WRDS without special casing.
  logic [NW_PAD-1:0][WRD_BITS:0] wrds;
  genvar g;
  generate
    for (g = 0; g < NW_PAD; g++) begin : g_wrd
      if (g < NUM_WRDS) begin : g_real
        assign wrds[g] = act_q[g*(WRD_BITS+1) +: WRD_BITS+1];
      end else begin : g_pad
        assign wrds[g] = '0;
      end
    end
  endgenerate

  // Beat sum: WPB overlapping words plus the carry from the previous beat.
  logic [SW-1:0] sum;
  logic [IW-1:0] idx;
  always_comb begin
    sum = SW'(carry_q);
    idx = '0;
    for (int j = 0; j < WPB; j++) begin
      idx = IW'(int'(k_q) * WPB + j);
      sum = sum + (SW'(wrds[idx]) << (j * WRD_BITS));
    end
  end

  logic is_last, beat_fire, cap_fire;
  assign is_last   = (state == STREAM) && (k_q == KW'(NUM_BEATS - 1));
  assign o_val     = (state == STREAM);
  assign beat_fire = o_val && i_rdy;
  assign cap_fire  = i_val && o_rdy;
  assign o_dat     = o_val ? sum[OUT_BITS-1:0] : '0;
  assign o_last    = is_last;
  assign o_ovf     = is_last && (|sum[SW-1:TOP_LSB]);

`ifdef REDUN_SER_DBUF_EN
  assign o_rdy = up_q && ((state == IDLE) || !sh_full);
`else
  assign o_rdy = up_q && (state == IDLE);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      up_q    <= 1'b0;
      k_q     <= '0;
      carry_q <= '0;
      act_q   <= '0;
`ifdef REDUN_SER_DBUF_EN
      sh_q    <= '0;
      sh_full <= 1'b0;
`endif
    end else begin
      up_q <= 1'b1;
      case (state)
        IDLE: begin
          if (cap_fire) begin
            act_q   <= i_dat;
            k_q     <= '0;
            carry_q <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
`ifdef REDUN_SER_DBUF_EN
          // A capture coinciding with the last beat bypasses the shadow.
          if (cap_fire && !(beat_fire && is_last)) begin
            sh_q    <= i_dat;
            sh_full <= 1'b1;
          end
`endif
          if (beat_fire) begin
            carry_q <= sum[SW-1:OUT_BITS];
            k_q     <= k_q + 1'b1;
            if (is_last) begin
`ifdef REDUN_SER_DBUF_EN
              if (sh_full) begin
                act_q   <= sh_q;
                sh_full <= 1'b0;
                k_q     <= '0;
                carry_q <= '0;
              end else if (cap_fire) begin
                act_q   <= i_dat;
                k_q     <= '0;
                carry_q <= '0;
              end else begin
                state <= IDLE;
              end
`else
              state <= IDLE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/redun_result_serializer.md
Name: redun_result_serializer

Overview:
- Downstream stage of the redundant-form Montgomery squaring core.
- Captures one redundant result of NUM_WRDS words, each WRD_BITS+1 bits. Resolves the carries serially. Streams the canonical DAT_BITS-bit binary value out as OUT_BITS-bit beats on a valid/ready interface toward the MSU/AXI side.
- Carry resolution is interleaved with output beats, so no full-width adder is needed.

Parameters:
- WRD_BITS, 16: bits per redundant word, excluding the redundant carry bit.
- NUM_WRDS, 65: redundant words per result. DAT_BITS = NUM_WRDS*WRD_BITS = 1040.
- OUT_BITS, 32: output beat width. Must be a multiple of WRD_BITS. WPB = OUT_BITS/WRD_BITS = 2.
- NUM_BEATS, 33: ceil(DAT_BITS/OUT_BITS).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dat  in  NUM_WRDS*(WRD_BITS+1)  redundant result; word k occupies bits [k*(WRD_BITS+1) +: WRD_BITS+1]
- i_val  in  1  input valid
- o_rdy  out  1  input ready
- o_dat  out  OUT_BITS  output beat, least-significant beat first
- o_val  out  1  output valid
- i_rdy  in  1  downstream ready
- o_last  out  1  high on beat NUM_BEATS-1
- o_ovf  out  1  overflow flag, valid with o_last

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0 and after it:
  - o_rdy=0, o_val=0, o_last=0, o_ovf=0, o_dat=0.
  - State=IDLE, beat counter=0, carry register=0, capture register=0.
- First i_clk edge after release: o_rdy=1.
- States:
  - IDLE: o_rdy=1, o_val=0. If i_val&&o_rdy, capture i_dat, clear carry and beat counter, go to STREAM.
  - STREAM: o_rdy=0, o_val=1.
    - o_dat = sum over j<WPB of (word[k*WPB+j] << j*WRD_BITS), plus carry, truncated to OUT_BITS.
    - The sum is formed in OUT_BITS+2 bits. Words with index ≥ NUM_WRDS contribute 0.
    - On i_rdy&&o_val: carry <= sum[OUT_BITS+1:OUT_BITS] (2-bit carry; its maximum is 2), k <= k+1.
    - On the handshake with k=NUM_BEATS-1: go to IDLE.
- Latency: first beat is valid the cycle after input capture. With i_rdy held high, the stream is NUM_BEATS consecutive cycles. o_rdy returns high the cycle after the last handshake.
- o_dat, o_last and o_ovf are combinational from the registers and are held stable while o_val&&!i_rdy. i_rdy low stalls indefinitely without loss.
- o_last = (k==NUM_BEATS-1) in STREAM.
- o_ovf is asserted with o_last if the final sum has any bit at or above DAT_BITS set. These are bits [OUT_BITS+1 : DAT_BITS-(NUM_BEATS-1)*OUT_BITS] of the final sum, i.e. the final carry is nonzero or beat bits 31:16 are nonzero.
- i_val while o_rdy=0 is ignored and is not captured. The upstream holds i_val until it sees o_rdy.
- i_dat is sampled only on the capture edge. Changes to i_dat after capture have no effect.
- Reset asserted mid-stream: immediate return to reset values. The partial stream is abandoned and no o_last is produced.

Optional Feature:
- Macro: REDUN_SER_DBUF_EN.
- Defined:
  - A shadow capture register is added.
  - In STREAM, o_rdy = shadow empty, so a second result may be accepted during streaming.
  - On the last-beat handshake with the shadow full: shadow moves to the active register and streaming continues with k=0 and carry=0 on the next cycle. There is no IDLE bubble, and the first beat of the next result follows o_last back-to-back.
  - A capture and a last-beat handshake in the same cycle with the shadow empty: the new input is loaded directly into the active register.
- Not defined: single register only; o_rdy=0 throughout STREAM.

Test Plan:
- Reset, then i_dat=all zero except word0=0x1FFFF, i_rdy=1 -> beat0=0x0001FFFF, beats1..32=0, o_last on beat32, o_ovf=0, o_rdy high the cycle after beat32.
- i_dat=to_redun(P) -> beats equal P[32k+:32] (beat0=0x88E2666B), beat32=0x00000000, o_ovf=0.
- Carry ripple: words1..64=0xFFFF, word0=0x10000 (value 2^1040) -> beats0..31=0, beat32=0x00010000, o_ovf=1.
- Backpressure: the ripple input with i_rdy toggled 1,0,0,1,... (pseudo-random) -> identical beat sequence; o_dat stable while stalled; o_val never drops until the last handshake.
- Reset pulse at beat 10 -> o_val=0 immediately and all outputs at reset values. The next input streams correctly from beat0 with carry cleared.
- REDUN_SER_DBUF_EN: two results issued back-to-back -> second accepted during the first stream; 66 beats in 66 cycles with i_rdy=1; two o_last pulses.
